// File: rtl/out_frame_fifo_pkg.sv
// Shared definitions for the output-frame streaming path.
package out_stream_pkg;

   localparam int PIX_W  = 8;
   localparam int BEAT_W = 3 * PIX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/out_frame_fifo_if.sv
// Three-channel pixel stream with valid/ready handshake and end-of-line flag.
interface out_frame_fifo_if;
   import out_stream_pkg::*;

   logic [PIX_W-1:0] data0;
   logic [PIX_W-1:0] data1;
   logic [PIX_W-1:0] data2;
   logic             valid;
   logic             ready;
   logic             eol;

   // Producer side: drives beats and the line marker.
   modport master (output data0, data1, data2, valid, eol, input ready);
   // Consumer side: the line marker is not needed on the upstream leg.
   modport slave  (input data0, data1, data2, valid, output ready);
endinterface

// File: rtl/out_frame_fifo_sync_fifo.sv
// Registered-output synchronous FIFO; a written entry is visible one cycle later.
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_wr_s;
   logic             do_rd_s;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == CNT_W'(0));
   assign do_wr_s = wr_en & ~full;
   assign do_rd_s = rd_en & ~empty;
   assign rd_data = mem_q[rd_ptr_q];

   // Next storage, pointer and occupancy; pointers wrap since DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr_s) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_rd_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_wr_s, do_rd_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage and pointer registers; reset clears contents so the head reads zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= WIDTH'(0);
         end
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         cnt_q    <= CNT_W'(0);
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/out_frame_fifo.sv
// Frame-bounded output buffer: accepts exactly one frame of beats per start
// pulse, forwards them through a small FIFO and flags line ends and frame done.
module out_frame_fifo
   import out_stream_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IMG_W = 256,
   parameter int IMG_H = 256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_in,
   out_frame_fifo_if.slave         in_if,
   out_frame_fifo_if.master        out_if,
   output logic                    stop_out
);
   localparam int FRAME = IMG_W * IMG_H;
   localparam int CNT_W = $clog2(FRAME + 1);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              stop_out_q, stop_out_d;

   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [BEAT_W-1:0] fifo_rd_data_s;
   logic              in_ready_s;
   logic              push_s;
   logic              pop_s;

   // Ready depends only on registered state so it never loops back through valid.
   assign in_ready_s   = (state_q == RUN) & ~fifo_full_s & (in_cnt_q < CNT_W'(FRAME));
   assign in_if.ready  = in_ready_s;
   assign push_s       = in_if.valid & in_ready_s;
   assign out_if.valid = ~fifo_empty_s;
   assign pop_s        = out_if.valid & out_if.ready;
   assign out_if.data0 = fifo_rd_data_s[PIX_W-1:0];
   assign out_if.data1 = fifo_rd_data_s[2*PIX_W-1:PIX_W];
   assign out_if.data2 = fifo_rd_data_s[3*PIX_W-1:2*PIX_W];
   assign out_if.eol   = out_if.valid & (col_q == COL_W'(IMG_W - 1));
   assign stop_out     = stop_out_q;

   sync_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_s),
      .wr_data ({in_if.data2, in_if.data1, in_if.data0}),
      .rd_en   (pop_s),
      .rd_data (fifo_rd_data_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   // Frame FSM and beat/column counters; a start only takes effect outside RUN.
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      col_d     = col_q;
      if (push_s) begin
         in_cnt_d = in_cnt_q + CNT_W'(1);
      end else begin
         in_cnt_d = in_cnt_q;
      end
      if (pop_s) begin
         out_cnt_d = out_cnt_q + CNT_W'(1);
         col_d     = (col_q == COL_W'(IMG_W - 1)) ? COL_W'(0) : col_q + COL_W'(1);
      end else begin
         out_cnt_d = out_cnt_q;
         col_d     = col_q;
      end
      case (state_q)
         IDLE, DONE: begin
            if (start_in) begin
               state_d   = RUN;
               in_cnt_d  = CNT_W'(0);
               out_cnt_d = CNT_W'(0);
               col_d     = COL_W'(0);
            end else begin
               state_d = state_q;
            end
         end
         RUN: begin
            if (pop_s && (out_cnt_q == CNT_W'(FRAME - 1))) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
      stop_out_d = (state_d == DONE);
   end

   // Control registers; reset dominates start and both handshakes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         in_cnt_q   <= CNT_W'(0);
         out_cnt_q  <= CNT_W'(0);
         col_q      <= COL_W'(0);
         stop_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         col_q      <= col_d;
         stop_out_q <= stop_out_d;
      end
   end
endmodule

// File: doc/out_frame_fifo.md
OUT_FRAME_FIFO -- requirements
Module: out_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, >=2.
REQ-002 SHALL have parameter IMG_W, default 256: beats per line.
REQ-003 SHALL have parameter IMG_H, default 256: lines per frame.
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start_in  in  1  frame start pulse.
REQ-007 SHALL have ports in_data0/in_data1/in_data2  in  8 each  upstream pixel channels.
REQ-008 SHALL have port in_valid  in  1  upstream beat valid.
REQ-009 SHALL have port in_ready  out  1  block accepts beat.
REQ-010 SHALL have ports out_data0/out_data1/out_data2  out  8 each  pixel channels to sink.
REQ-011 SHALL have port out_valid  out  1  head entry valid.
REQ-012 SHALL have port out_ready  in  1  sink accepts beat.
REQ-013 SHALL have port out_eol  out  1  head beat is last of its line.
REQ-014 SHALL have port stop_out  out  1  frame fully delivered.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start_in; RUN->DONE on the out handshake of beat IMG_W*IMG_H-1; DONE->RUN on start_in; no other transitions.
REQ-016 SHALL count a push when in_valid & in_ready, and a pop when out_valid & out_ready.
REQ-017 SHALL drive in_ready = (state==RUN) & !full & (in_cnt < IMG_W*IMG_H); in_ready combinational from registers only, never from in_valid or out_ready.
REQ-018 SHALL drive out_valid = !empty, independent of state.
REQ-019 SHALL present pushed data on out_data* exactly one cycle after the push at the earliest (no fall-through); out_data* SHALL hold stable while out_valid & !out_ready.
REQ-020 SHALL keep occupancy unchanged on a simultaneous push and pop; full at occupancy DEPTH, empty at 0; pointers wrap modulo DEPTH.
REQ-021 SHALL keep in_cnt and out_cnt as ceil(log2(IMG_W*IMG_H+1))-bit counters, cleared on start_in.
REQ-022 SHALL keep a column counter 0..IMG_W-1 advancing on each pop, wrapping to 0; out_eol = out_valid & (col==IMG_W-1).
REQ-023 SHALL assert stop_out as a registered level in DONE, deasserting in the cycle following start_in.
REQ-024 SHALL ignore start_in while in RUN.
REQ-025 SHALL, on start_in in IDLE or DONE, clear in_cnt/out_cnt/col; FIFO is empty at that point by construction.

Reset
REQ-026 SHALL, on reset, enter IDLE, empty the FIFO, clear all counters; outputs in_ready=0, out_valid=0, out_eol=0, stop_out=0, out_data*=0.
REQ-027 SHALL, on reset mid-frame, discard all buffered beats with no further out_valid until new data after a fresh start_in.
REQ-028 SHALL give reset priority over start_in and both handshakes in the same cycle.

Structure
REQ-029 SHALL place the state enum and the pixel width constant (8) in shared package out_stream_pkg.
REQ-030 SHALL instantiate exactly one sub-module, sync_fifo (parameterized width 24, DEPTH), holding {in_data2,in_data1,in_data0}; control FSM and counters live in out_frame_fifo.

Verification
REQ-031 SHALL test: IMG_W=4, IMG_H=2, out_ready=1, continuous in_valid, start_in pulse -> 8 beats out in order, out_eol on beats 3 and 7, stop_out=1 the cycle after beat 7 handshake.
REQ-032 SHALL test: out_ready=0, 5 upstream beats offered with DEPTH=4 -> in_ready=0 after 4 pushes, out_data* held at beat 0 values.
REQ-033 SHALL test: random in_valid and out_ready (each 50%), IMG_W=256, IMG_H=256 -> 65536 beats out, values equal to input sequence, 256 out_eol pulses, no beat accepted after in_cnt=65536.
REQ-034 SHALL test: reset asserted after 10 of 16 beats with 3 buffered -> next cycle out_valid=0, stop_out=0, state IDLE; new start_in yields a correct full frame.
REQ-035 SHALL test: start_in while RUN mid-frame -> no effect on counters; start_in in DONE -> stop_out drops next cycle, second frame delivered.
REQ-036 SHALL test: reset and start_in in the same cycle -> IDLE, in_ready=0.
